// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Write-back arbiter for the 16 x 16-bit register file. Requester 0 is the
//   ALU result and requester 1 is the memory load return. The two requesters
//   share the single write port of the register file, which is fed by the
//   1-to-16 demux tree.
//
//   Structure:
//     - round-robin grant between the two requesters, issued only while the
//       one-entry output stage is free (empty, or draining this cycle)
//     - one-entry output stage holding valid / select / data for the demux
//     - saturating counter of cycles in which both requesters were valid
//
//   Optional feature (macro WB_R0_ZERO_EN):
//     When defined, register 0 is hardwired to zero. Writes to address 0 are
//     still handshaken and arbitrated, but they never raise the write strobe.
//     When undefined, address 0 is an ordinary writable register.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  input  logic             wb_stall,
  output logic             wr_en,
  output logic [AW-1:0]    wr_sel,
  output logic [DW-1:0]    wr_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Output stage and bookkeeping state
  logic             r_out_valid;
  logic [AW-1:0]    r_wr_sel;
  logic [DW-1:0]    r_wr_data;
  logic [CNT_W-1:0] r_conflict_cnt;
  logic             r_rr;           // 0: requester 0 wins the next tie

  // Combinational arbitration results
  logic             w_stage_free;
  logic             w_both_valid;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_any_grant;
  logic [AW-1:0]    w_win_addr;
  logic [DW-1:0]    w_win_data;
  logic             w_load_valid;
  logic             w_cnt_sat;

  // The stage can take a new entry when it is empty or is being written now.
  assign w_stage_free = (~r_out_valid) | (~wb_stall);
  assign w_both_valid = req0_valid & req1_valid;
  assign w_any_grant  = w_grant0 | w_grant1;
  assign w_cnt_sat    = &r_conflict_cnt;

  // Round-robin grant: single requester wins outright, a tie goes to r_rr.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_stage_free) begin
      case ({req1_valid, req0_valid})
        2'b01: w_grant0 = 1'b1;
        2'b10: w_grant1 = 1'b1;
        2'b11: begin
          if (r_rr == 1'b0) begin
            w_grant0 = 1'b1;
          end else begin
            w_grant1 = 1'b1;
          end
        end
        default: begin
          w_grant0 = 1'b0;
          w_grant1 = 1'b0;
        end
      endcase
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // Select the winning requester's destination and data for the stage.
  always_comb begin
    w_win_addr = req0_addr;
    w_win_data = req0_data;
    if (w_grant1) begin
      w_win_addr = req1_addr;
      w_win_data = req1_data;
    end else begin
      w_win_addr = req0_addr;
      w_win_data = req0_data;
    end
  end

`ifdef WB_R0_ZERO_EN
  // Register 0 reads as zero: a granted write to it is accepted but dropped.
  assign w_load_valid = (w_win_addr != {AW{1'b0}});
`else
  // Every granted write is issued, including writes to register 0.
  assign w_load_valid = 1'b1;
`endif

  // Output stage: load on grant, empty when free and idle, hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_wr_sel    <= {AW{1'b0}};
      r_wr_data   <= {DW{1'b0}};
    end else if (w_any_grant) begin
      r_out_valid <= w_load_valid;
      r_wr_sel    <= w_win_addr;
      r_wr_data   <= w_win_data;
    end else if (w_stage_free) begin
      r_out_valid <= 1'b0;
      r_wr_sel    <= r_wr_sel;
      r_wr_data   <= r_wr_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_wr_sel    <= r_wr_sel;
      r_wr_data   <= r_wr_data;
    end
  end

  // Round-robin pointer moves away from the winner of a contested grant only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (w_both_valid && w_any_grant) begin
      r_rr <= w_grant0;
    end else begin
      r_rr <= r_rr;
    end
  end

  // Conflict counter: one per cycle with both requests valid, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= {CNT_W{1'b0}};
    end else if (w_both_valid && !w_cnt_sat) begin
      r_conflict_cnt <= r_conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  // The write strobe drops in the same cycle as a stall is raised.
  assign wr_en        = r_out_valid & (~wb_stall);
  assign wr_sel       = r_wr_sel;
  assign wr_data      = r_wr_data;
  assign conflict_cnt = r_conflict_cnt;
  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model: a queue of pending writes, a "who wins the next tie"
//   note and a saturating integer counter. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge.
//   Compile with +define+WB_R0_ZERO_EN to exercise the register-0 option.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [3:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_addr;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        wb_stall;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic [15:0] conflict_cnt;

  regfile_wb_arbiter #(.DW(16), .AW(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .wb_stall     (wb_stall),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  wr_t pend_q[$];        // writes accepted but not yet issued (0 or 1 entry)
  int  tie_winner = 0;   // requester that wins the next simultaneous request
  int  mdl_cnt    = 0;   // cycles with both requests valid, saturating
  logic mdl_g0, mdl_g1;  // model grants of the last cycle

  // Values observed on the last falling edge
  logic        obs_r0, obs_r1, obs_en;
  logic [3:0]  obs_sel;
  logic [15:0] obs_data;
  logic [15:0] obs_cnt;

  // Count one comparison and report it when it does not match.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    tie_winner = 0;
    mdl_cnt    = 0;
  endtask

  // One clock cycle: sample and compare at the falling edge, advance the
  // model, return 1 ns after the next rising edge.
  task automatic tick();
    bit free;
    bit exp_en;
    bit zero_drop;
    wr_t w;
    @(negedge clk);
    obs_r0   = req0_ready;
    obs_r1   = req1_ready;
    obs_en   = wr_en;
    obs_sel  = wr_sel;
    obs_data = wr_data;
    obs_cnt  = conflict_cnt;

    free   = (pend_q.size() == 0) || !wb_stall;
    exp_en = (pend_q.size() != 0) && !wb_stall;
    mdl_g0 = 1'b0;
    mdl_g1 = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin
        if (tie_winner == 0) mdl_g0 = 1'b1;
        else                 mdl_g1 = 1'b1;
      end else if (req0_valid) begin
        mdl_g0 = 1'b1;
      end else if (req1_valid) begin
        mdl_g1 = 1'b1;
      end
    end

    check_eq("req0_ready", {31'd0, obs_r0}, {31'd0, mdl_g0});
    check_eq("req1_ready", {31'd0, obs_r1}, {31'd0, mdl_g1});
    check_eq("wr_en", {31'd0, obs_en}, {31'd0, exp_en});
    if (pend_q.size() != 0) begin
      check_eq("wr_sel", {28'd0, obs_sel}, {28'd0, pend_q[0].addr});
      check_eq("wr_data", {16'd0, obs_data}, {16'd0, pend_q[0].data});
    end
    check_eq("conflict_cnt", {16'd0, obs_cnt}, mdl_cnt);

    if (exp_en) void'(pend_q.pop_front());
    if (mdl_g0 || mdl_g1) begin
      w = mdl_g0 ? wr_t'{req0_addr, req0_data} : wr_t'{req1_addr, req1_data};
      zero_drop = 1'b0;
`ifdef WB_R0_ZERO_EN
      zero_drop = (w.addr == 4'd0);
`endif
      if (!zero_drop) pend_q.push_back(w);
      if (req0_valid && req1_valid) tie_winner = mdl_g0 ? 1 : 0;
    end
    if (req0_valid && req1_valid && mdl_cnt < 65535) mdl_cnt++;

    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = 4'd0; req0_data = 16'd0;
    req1_valid = 1'b0; req1_addr = 4'd0; req1_data = 16'd0;
    wb_stall   = 1'b0;
  endtask

  // Synchronous-looking reset pulse used between scenarios.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic r0_first_en;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_eq("rst_wr_sel", {28'd0, wr_sel}, 32'd0);
    check_eq("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check_eq("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'hBEEF;
    tick();
    check_eq("single_ready0", {31'd0, obs_r0}, 32'd1);
    req0_valid = 1'b0;
    tick();
    check_eq("single_en", {31'd0, obs_en}, 32'd1);
    check_eq("single_sel", {28'd0, obs_sel}, 32'd3);
    check_eq("single_data", {16'd0, obs_data}, 32'hBEEF);
    tick();
    check_eq("single_en_off", {31'd0, obs_en}, 32'd0);

    // Contention, four cycles
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("cont_ready0", {31'd0, obs_r0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) check_eq("cont_sel", {28'd0, obs_sel}, (i % 2 == 1) ? 32'd1 : 32'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check_eq("cont_sel_last", {28'd0, obs_sel}, 32'd2);
    check_eq("cont_cnt", {16'd0, obs_cnt}, 32'd4);

    // Stall holding a load write while an ALU request waits
    do_reset();
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 16'h00A5;
    tick();
    check_eq("stall_grant1", {31'd0, obs_r1}, 32'd1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h0909;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_en", {31'd0, obs_en}, 32'd0);
      check_eq("stall_sel", {28'd0, obs_sel}, 32'd5);
      check_eq("stall_data", {16'd0, obs_data}, 32'h00A5);
      check_eq("stall_ready0", {31'd0, obs_r0}, 32'd0);
    end
    wb_stall = 1'b0;
    tick();
    check_eq("release_en", {31'd0, obs_en}, 32'd1);
    check_eq("release_sel", {28'd0, obs_sel}, 32'd5);
    check_eq("release_ready0", {31'd0, obs_r0}, 32'd1);
    req0_valid = 1'b0;
    tick();
    check_eq("after_en", {31'd0, obs_en}, 32'd1);
    check_eq("after_sel", {28'd0, obs_sel}, 32'd9);
    tick();
    check_eq("after_idle", {31'd0, obs_en}, 32'd0);

    // Reset mid-operation
    req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 16'h6666;
    req1_valid = 1'b1; req1_addr = 4'd8; req1_data = 16'h8888;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("pre_rst_en", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_en", {31'd0, wr_en}, 32'd0);
    check_eq("mid_rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_en", {31'd0, obs_en}, 32'd0);
    tick();
    check_eq("post_rst_en2", {31'd0, obs_en}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    check_eq("post_rst_rr", {31'd0, obs_r0}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();

    // Register-0 writes
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd0; req0_data = 16'h1234;
    tick();
    check_eq("r0_ready_a", {31'd0, obs_r0}, 32'd1);
    req0_addr = 4'd7; req0_data = 16'h5678;
    tick();
    check_eq("r0_ready_b", {31'd0, obs_r0}, 32'd1);
`ifdef WB_R0_ZERO_EN
    r0_first_en = 1'b0;
`else
    r0_first_en = 1'b1;
`endif
    check_eq("r0_en_addr0", {31'd0, obs_en}, {31'd0, r0_first_en});
    req0_valid = 1'b0;
    tick();
    check_eq("r0_en_addr7", {31'd0, obs_en}, 32'd1);
    check_eq("r0_sel_addr7", {28'd0, obs_sel}, 32'd7);
    check_eq("r0_data_addr7", {16'd0, obs_data}, 32'h5678);
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wb_stall = ($urandom_range(0, 3) == 0);
      tick();
      if (mdl_g0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = 4'($urandom_range(0, 15));
        req0_data  = 16'($urandom);
      end
      if (mdl_g1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = 4'($urandom_range(0, 15));
        req1_data  = 16'($urandom);
      end
    end
    idle_inputs();
    tick();
    tick();

    // Counter saturation under permanent contention and stall
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 16'h0044;
    req1_valid = 1'b1; req1_addr = 4'd11; req1_data = 16'h00BB;
    wb_stall = 1'b1;
    repeat (65541) tick();
    check_eq("sat_cnt", {16'd0, conflict_cnt}, 32'hFFFF);
    repeat (3) tick();
    check_eq("sat_hold", {16'd0, conflict_cnt}, 32'hFFFF);
    idle_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter for the 16-entry x 16-bit register file. Its write port is built from the 1-to-16 16-bit demux tree.
- Shares the single write port between two requesters: requester 0 is the ALU result and requester 1 is the memory load return.
- Arbitrates round-robin, registers the winner into a one-entry output stage, and drives the demux select, data and write enable.
- Also counts conflict cycles for performance statistics.

Parameters:
- DW, 16, data width. Must match the demux word width.
- AW, 4, register address width. Drives the demux select.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU write request.
- req0_addr  in  AW  ALU destination register.
- req0_data  in  DW  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load write request.
- req1_addr  in  AW  load destination register.
- req1_data  in  DW  load data.
- req1_ready  out  1  load request accepted this cycle.
- wb_stall  in  1  register file cannot accept a write this cycle.
- wr_en  out  1  write strobe to the demux/register file.
- wr_sel  out  AW  demux select, i.e. destination register.
- wr_data  out  DW  demux input data.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests valid.

Behaviour:
- Reset: an asynchronous assert of rst_n=0 clears the following immediately.
  - out_valid=0, wr_sel=0, wr_data=0, conflict_cnt=0.
  - Round-robin pointer rr=0, meaning requester 0 has priority next.
  - A write in flight when reset asserts is lost. No partial write is issued after deassert.
- Output stage: registers out_valid, wr_sel, wr_data.
  - wr_en = out_valid & ~wb_stall (combinational).
  - The stage is free when ~out_valid | ~wb_stall.
- Grant (combinational, only when the stage is free):
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by rr.
  - Stage not free: no grant. Both ready outputs are 0 and requesters hold valid/addr/data stable.
  - reqN_ready = grantN. A handshake completes on a cycle with valid & ready.
- Update on each rising edge:
  - On a grant, load the stage with the winner's addr/data and set out_valid=1. Latency from handshake to wr_en is 1 cycle, or longer under stall.
  - With no grant and the stage free, clear out_valid.
  - With the stage not free, hold out_valid, wr_sel and wr_data unchanged.
- Round-robin: rr flips only on a cycle where both requests were valid and a grant occurred. The new rr points away from the winner. A single-requester grant leaves rr unchanged.
- Throughput: 1 write per cycle while wb_stall=0. Back-to-back grants to the same requester are allowed when the other is idle.
- Same-address conflict: both requesters target the same register in the same cycle. Arbitration is normal, and the two writes issue in grant order on consecutive writes; the later write persists.
- Stall: wb_stall may rise at any time, and wr_en drops in that same cycle. The stage holds until wb_stall=0, then writes exactly once.
- conflict_cnt: increments by 1 on every cycle with req0_valid & req1_valid, including stalled cycles. It saturates at all-ones and never wraps.

Optional Feature:
- Macro WB_R0_ZERO_EN.
- Defined (register 0 hardwired to zero):
  - Requests with addr=0 are handshaken normally and go through arbitration, rr update and stage load as usual.
  - out_valid is forced to 0 for them, so wr_en never asserts with wr_sel=0.
- Undefined: addr 0 is an ordinary writable register.

Test Plan:
- Single ALU write: req0 addr=3, data=0xBEEF, wb_stall=0.
  - Required: req0_ready=1 in cycle 0.
  - Required: next cycle wr_en=1, wr_sel=3, wr_data=0xBEEF.
  - Required: following cycle wr_en=0.
- Contention: both valid for 4 cycles, req0 addr=1/data=0x1111 and req1 addr=2/data=0x2222, rr=0 after reset.
  - Required: grants alternate 0,1,0,1.
  - Required: wr_sel sequence 1,2,1,2.
  - Required: conflict_cnt=4.
- Stall: grant req1 (addr=5, data=0x00A5), then wb_stall=1 for 3 cycles.
  - Required: wr_en=0 and wr_sel/wr_data held at 5/0x00A5 throughout.
  - Required: both ready=0 while a new req0 is pending.
  - Required: on stall release, exactly one write to register 5, then the req0 grant.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and wr_en would be 1.
  - Required: wr_en=0 immediately.
  - Required: conflict_cnt=0 and rr=0.
  - Required: no write after deassert until a new handshake.
- Saturation: hold both valid with wb_stall=1 for 2^16+5 cycles.
  - Required: conflict_cnt=0xFFFF and stays there.
- WB_R0_ZERO_EN: req0 addr=0/data=0x1234, then addr=7/data=0x5678.
  - Defined: both handshake, wr_en only for the addr=7 write.
  - Undefined: wr_en for both writes.
